// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate divider, h/v counters, source position
// requests, PIPE_LAT-aligned registered colour/sync/blank DAC outputs.
// Ports: CLOCK_50, reset (sync, active-low), red/green/blue_in ->
//   VGA_R/G/B, VGA_HS/VS, VGA_CLK, VGA_BLANK_N, VGA_SYNC_N,
//   next_x/next_y/next_valid, pix_ce, line_start, frame_start.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIPE_LAT = 1,
  parameter int COLOR_W  = 8,
  parameter int XW       = 10,
  parameter int YW       = 10
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic [COLOR_W-1:0] red_in,
  input  logic [COLOR_W-1:0] green_in,
  input  logic [COLOR_W-1:0] blue_in,
  output logic [COLOR_W-1:0] VGA_R,
  output logic [COLOR_W-1:0] VGA_G,
  output logic [COLOR_W-1:0] VGA_B,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic               VGA_CLK,
  output logic               VGA_BLANK_N,
  output logic               VGA_SYNC_N,
  output logic [XW-1:0]      next_x,
  output logic [YW-1:0]      next_y,
  output logic               next_valid,
  output logic               pix_ce,
  output logic               line_start,
  output logic               frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int DW = $clog2(CLK_DIV);

  localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] D_HALF = DW'(CLK_DIV / 2);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_nxt;
  logic [HW-1:0] hc;
  logic [VW-1:0] vc;
  logic          act;
  logic          hs;
  logic          vs;
  logic          act_d;
  logic          hs_d;
  logic          vs_d;

  always_comb begin
    div_nxt = (div_cnt == D_LAST) ? '0 : div_cnt + DW'(1);
    pix_ce  = reset && (div_cnt == D_LAST);
    act = (hc < H_ACT) && (vc < V_ACT);
    hs  = (hc >= HS_BEG) && (hc < HS_END);
    vs  = (vc >= VS_BEG) && (vc < VS_END);
    next_x      = XW'(hc);
    next_y      = YW'(vc);
    next_valid  = act;
    line_start  = pix_ce && (hc == '0) && (vc < V_ACT);
    frame_start = pix_ce && (hc == '0) && (vc == '0);
  end

  assign VGA_SYNC_N = 1'b0;

  // VGA_CLK mirrors div_cnt's upper half, registered from the next
  // count so the pix_ce update edge is its falling edge.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      div_cnt <= '0;
      VGA_CLK <= 1'b0;
      hc      <= '0;
      vc      <= '0;
    end else begin
      div_cnt <= div_nxt;
      VGA_CLK <= (div_nxt >= D_HALF);
      if (pix_ce) begin
        if (hc == H_LAST) begin
          hc <= '0;
          vc <= (vc == V_LAST) ? '0 : vc + VW'(1);
        end else begin
          hc <= hc + HW'(1);
        end
      end
    end
  end

  generate
    if (PIPE_LAT == 0) begin : g_nodly
      assign act_d = act;
      assign hs_d  = hs;
      assign vs_d  = vs;
    end else begin : g_dly
      logic [PIPE_LAT-1:0] act_sr;
      logic [PIPE_LAT-1:0] hs_sr;
      logic [PIPE_LAT-1:0] vs_sr;

      always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
          act_sr <= '0;
          hs_sr  <= '0;
          vs_sr  <= '0;
        end else if (pix_ce) begin
          act_sr <= (act_sr << 1) | PIPE_LAT'(act);
          hs_sr  <= (hs_sr << 1) | PIPE_LAT'(hs);
          vs_sr  <= (vs_sr << 1) | PIPE_LAT'(vs);
        end
      end

      assign act_d = act_sr[PIPE_LAT-1];
      assign hs_d  = hs_sr[PIPE_LAT-1];
      assign vs_d  = vs_sr[PIPE_LAT-1];
    end
  endgenerate

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      VGA_BLANK_N <= 1'b0;
      VGA_HS      <= ~HS_POL;
      VGA_VS      <= ~VS_POL;
    end else if (pix_ce) begin
      VGA_R       <= act_d ? red_in : '0;
      VGA_G       <= act_d ? green_in : '0;
      VGA_B       <= act_d ? blue_in : '0;
      VGA_BLANK_N <= act_d;
      VGA_HS      <= hs_d ? HS_POL : ~HS_POL;
      VGA_VS      <= vs_d ? VS_POL : ~VS_POL;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: three configurations share one
// clock/reset; directed per-tick expectations are checked on pix_ce.
module tb_vga_timing_gen;

  localparam int S_X = 0, S_Y = 1, S_FS = 2, S_LS = 3, S_NV = 4;
  localparam int S_HS = 5, S_VS = 6, S_BN = 7, S_R = 8, S_G = 9;
  localparam int S_CLK = 10, S_PCE = 11, S_CYC = 12, S_CLK0 = 13;

  typedef struct {
    int    tick;
    int    sig;
    int    exp;
    string name;
  } vec_t;

  logic CLOCK_50 = 1'b0;
  logic reset;
  always #10 CLOCK_50 = ~CLOCK_50;

  logic [7:0] red0, grn0, blu0, red1, grn1, blu1, red2, grn2, blu2;
  logic [7:0] r0, g0, b0, r1, g1, b1, r2, g2, b2;
  logic hs0, vs0, clk0, bn0, sn0, nv0, pce0, ls0, fs0;
  logic hs1, vs1, clk1, bn1, sn1, nv1, pce1, ls1, fs1;
  logic hs2, vs2, clk2, bn2, sn2, nv2, pce2, ls2, fs2;
  logic [9:0] x0, y0, x1, y1, x2, y2;

  vga_timing_gen u0 (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .red_in(red0), .green_in(grn0), .blue_in(blu0),
    .VGA_R(r0), .VGA_G(g0), .VGA_B(b0),
    .VGA_HS(hs0), .VGA_VS(vs0), .VGA_CLK(clk0),
    .VGA_BLANK_N(bn0), .VGA_SYNC_N(sn0),
    .next_x(x0), .next_y(y0), .next_valid(nv0),
    .pix_ce(pce0), .line_start(ls0), .frame_start(fs0)
  );

  vga_timing_gen #(
    .PIPE_LAT(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u1 (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .red_in(red1), .green_in(grn1), .blue_in(blu1),
    .VGA_R(r1), .VGA_G(g1), .VGA_B(b1),
    .VGA_HS(hs1), .VGA_VS(vs1), .VGA_CLK(clk1),
    .VGA_BLANK_N(bn1), .VGA_SYNC_N(sn1),
    .next_x(x1), .next_y(y1), .next_valid(nv1),
    .pix_ce(pce1), .line_start(ls1), .frame_start(fs1)
  );

  vga_timing_gen #(
    .CLK_DIV(4), .HS_POL(1'b1), .VS_POL(1'b1),
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u2 (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .red_in(red2), .green_in(grn2), .blue_in(blu2),
    .VGA_R(r2), .VGA_G(g2), .VGA_B(b2),
    .VGA_HS(hs2), .VGA_VS(vs2), .VGA_CLK(clk2),
    .VGA_BLANK_N(bn2), .VGA_SYNC_N(sn2),
    .next_x(x2), .next_y(y2), .next_valid(nv2),
    .pix_ce(pce2), .line_start(ls2), .frame_start(fs2)
  );

  // Source model for u1: returns x[7:0] two pixel ticks late.
  logic [7:0] h0;
  always @(posedge CLOCK_50) begin
    if (!reset) begin
      h0   <= '0;
      red1 <= '0;
    end else if (pce1) begin
      red1 <= h0;
      h0   <= x1[7:0];
    end
  end

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int rel = 0;
  int rst_edges = 0;
  int t[3];
  bit lo_pend[3];
  int cur[3][14];
  vec_t sq[3][$];
  vec_t rq[$];

  function automatic void chk(string n, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", n, got, exp);
  endfunction

  function automatic void pv(int k, int tk, int s, int e, string n);
    vec_t v;
    v.tick = tk;
    v.sig  = s;
    v.exp  = e;
    v.name = $sformatf("u%0d_%s_t%0d", k, n, tk);
    sq[k].push_back(v);
  endfunction

  function automatic void pr(int k, int s, int e, string n);
    vec_t v;
    v.tick = k;
    v.sig  = s;
    v.exp  = e;
    v.name = $sformatf("u%0d_rst_%s", k, n);
    rq.push_back(v);
  endfunction

  function automatic void fill(int k, int x, int y, int fs, int ls,
                               int nv, int hs, int vs, int bn, int r,
                               int g, int ck, int pc);
    cur[k][S_X] = x;   cur[k][S_Y] = y;   cur[k][S_FS] = fs;
    cur[k][S_LS] = ls; cur[k][S_NV] = nv; cur[k][S_HS] = hs;
    cur[k][S_VS] = vs; cur[k][S_BN] = bn; cur[k][S_R] = r;
    cur[k][S_G] = g;   cur[k][S_CLK] = ck; cur[k][S_PCE] = pc;
    cur[k][S_CYC] = cyc - rel;
    cur[k][S_CLK0] = ck;
  endfunction

  always @(posedge CLOCK_50) begin
    cyc++;
    if (!reset) rst_edges++;
    else rst_edges = 0;
  end

  // Monitor: pops expectations as the DUTs present pixel ticks.
  always @(negedge CLOCK_50) begin
    vec_t e;
    fill(0, int'(x0), int'(y0), int'(fs0), int'(ls0), int'(nv0),
         int'(hs0), int'(vs0), int'(bn0), int'(r0), int'(g0),
         int'(clk0), int'(pce0));
    fill(1, int'(x1), int'(y1), int'(fs1), int'(ls1), int'(nv1),
         int'(hs1), int'(vs1), int'(bn1), int'(r1), int'(g1),
         int'(clk1), int'(pce1));
    fill(2, int'(x2), int'(y2), int'(fs2), int'(ls2), int'(nv2),
         int'(hs2), int'(vs2), int'(bn2), int'(r2), int'(g2),
         int'(clk2), int'(pce2));
    if (!reset) begin
      for (int k = 0; k < 3; k++) begin
        t[k] = -1;
        lo_pend[k] = 1'b0;
      end
      if (rst_edges > 0) begin
        while (rq.size() > 0) begin
          e = rq.pop_front();
          chk(e.name, cur[e.tick][e.sig], e.exp);
        end
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (lo_pend[k]) begin
          chk($sformatf("u%0d_vga_clk_low", k), cur[k][S_CLK], 0);
          lo_pend[k] = 1'b0;
        end
        if (cur[k][S_PCE] != 0) begin
          t[k]++;
          while (sq[k].size() > 0 && sq[k][0].tick == t[k]) begin
            e = sq[k].pop_front();
            if (e.sig == S_CLK0) lo_pend[k] = 1'b1;
            else chk(e.name, cur[k][e.sig], e.exp);
          end
        end
      end
    end
  end

  task automatic drain(string n);
    int left;
    left = 0;
    for (int i = 0; i < 20000; i++) begin
      left = sq[0].size() + sq[1].size() + sq[2].size();
      if (left == 0) break;
      @(negedge CLOCK_50);
    end
    chk(n, sq[0].size() + sq[1].size() + sq[2].size(), 0);
  endtask

  initial begin
    bit found;
    reset = 1'b0;
    red0 = 8'hc3; grn0 = 8'h11; blu0 = 8'h22;
    grn1 = 8'h5a; blu1 = 8'h3c;
    red2 = 8'hc3; grn2 = 8'h11; blu2 = 8'h22;

    pr(0, S_R, 0, "r");     pr(0, S_BN, 0, "bn");
    pr(0, S_HS, 1, "hs");   pr(0, S_VS, 1, "vs");
    pr(0, S_CLK, 0, "clk"); pr(0, S_PCE, 0, "pce");
    pr(0, S_FS, 0, "fs");   pr(0, S_X, 0, "x");
    pr(2, S_HS, 0, "hs");   pr(2, S_VS, 0, "vs");
    pr(2, S_CLK, 0, "clk");
    repeat (10) @(posedge CLOCK_50);

    // u0: default timing, PIPE_LAT=1 -> outputs trail position by 2.
    pv(0, 0, S_X, 0, "x");     pv(0, 0, S_Y, 0, "y");
    pv(0, 0, S_FS, 1, "fs");   pv(0, 0, S_LS, 1, "ls");
    pv(0, 0, S_NV, 1, "nv");   pv(0, 0, S_CLK, 1, "clk");
    pv(0, 0, S_CLK0, 0, "c0"); pv(0, 0, S_CYC, 1, "cyc");
    pv(0, 0, S_HS, 1, "hs");   pv(0, 0, S_BN, 0, "bn");
    pv(0, 1, S_CYC, 3, "cyc"); pv(0, 1, S_X, 1, "x");
    pv(0, 1, S_FS, 0, "fs");
    pv(0, 2, S_BN, 1, "bn");   pv(0, 2, S_R, 8'hc3, "r");
    pv(0, 639, S_NV, 1, "nv");
    pv(0, 640, S_NV, 0, "nv"); pv(0, 640, S_X, 640, "x");
    pv(0, 641, S_BN, 1, "bn");
    pv(0, 642, S_BN, 0, "bn"); pv(0, 642, S_R, 0, "r");
    pv(0, 657, S_HS, 1, "hs"); pv(0, 658, S_HS, 0, "hs");
    pv(0, 753, S_HS, 0, "hs"); pv(0, 754, S_HS, 1, "hs");
    pv(0, 799, S_X, 799, "x"); pv(0, 799, S_Y, 0, "y");
    pv(0, 800, S_X, 0, "x");   pv(0, 800, S_Y, 1, "y");
    pv(0, 800, S_LS, 1, "ls"); pv(0, 800, S_FS, 0, "fs");
    pv(0, 800, S_CYC, 1601, "cyc");
    pv(0, 1457, S_HS, 1, "hs"); pv(0, 1458, S_HS, 0, "hs");

    // u1: PIPE_LAT=2, 7-line frame; VGA_R at tick t is x(t-3).
    pv(1, 0, S_FS, 1, "fs");   pv(1, 0, S_CYC, 1, "cyc");
    pv(1, 2, S_BN, 0, "bn");   pv(1, 2, S_R, 0, "r");
    pv(1, 3, S_BN, 1, "bn");   pv(1, 3, S_R, 0, "r");
    pv(1, 3, S_G, 8'h5a, "g");
    pv(1, 103, S_R, 100, "r"); pv(1, 303, S_R, 44, "r");
    pv(1, 642, S_R, 127, "r"); pv(1, 642, S_BN, 1, "bn");
    pv(1, 643, S_R, 0, "r");   pv(1, 643, S_BN, 0, "bn");
    pv(1, 643, S_G, 0, "g");
    pv(1, 658, S_HS, 1, "hs"); pv(1, 659, S_HS, 0, "hs");
    pv(1, 803, S_BN, 1, "bn"); pv(1, 1003, S_R, 200, "r");
    pv(1, 3213, S_BN, 0, "bn"); pv(1, 3213, S_R, 0, "r");
    pv(1, 4002, S_VS, 1, "vs"); pv(1, 4003, S_VS, 0, "vs");
    pv(1, 4802, S_VS, 0, "vs"); pv(1, 4803, S_VS, 1, "vs");
    pv(1, 5599, S_X, 799, "x"); pv(1, 5599, S_Y, 6, "y");
    pv(1, 5599, S_FS, 0, "fs");
    pv(1, 5600, S_X, 0, "x");   pv(1, 5600, S_Y, 0, "y");
    pv(1, 5600, S_FS, 1, "fs"); pv(1, 5600, S_CYC, 11201, "cyc");
    pv(1, 5703, S_R, 100, "r");

    // u2: CLK_DIV=4, 12x7 raster, both syncs active-high.
    pv(2, 0, S_X, 0, "x");     pv(2, 0, S_Y, 0, "y");
    pv(2, 0, S_FS, 1, "fs");   pv(2, 0, S_CYC, 3, "cyc");
    pv(2, 0, S_CLK, 1, "clk"); pv(2, 0, S_CLK0, 0, "c0");
    pv(2, 1, S_CYC, 7, "cyc"); pv(2, 1, S_X, 1, "x");
    pv(2, 10, S_HS, 0, "hs");  pv(2, 11, S_HS, 1, "hs");
    pv(2, 12, S_HS, 1, "hs");  pv(2, 12, S_LS, 1, "ls");
    pv(2, 12, S_Y, 1, "y");    pv(2, 13, S_HS, 0, "hs");
    pv(2, 23, S_HS, 1, "hs");
    pv(2, 48, S_LS, 0, "ls");  pv(2, 48, S_Y, 4, "y");
    pv(2, 61, S_VS, 0, "vs");  pv(2, 62, S_VS, 1, "vs");
    pv(2, 73, S_VS, 1, "vs");  pv(2, 74, S_VS, 0, "vs");
    pv(2, 83, S_X, 11, "x");   pv(2, 83, S_Y, 6, "y");
    pv(2, 83, S_FS, 0, "fs");
    pv(2, 84, S_X, 0, "x");    pv(2, 84, S_Y, 0, "y");
    pv(2, 84, S_FS, 1, "fs");

    @(negedge CLOCK_50);
    reset = 1'b1;
    rel = cyc;
    drain("phase1_drain");

    found = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge CLOCK_50);
      if (x1 == 10'd300 && y1 == 10'd2) begin
        found = 1'b1;
        break;
      end
    end
    chk("u1_reach_300_2", int'(found), 1);

    pr(1, S_X, 0, "x");   pr(1, S_Y, 0, "y");
    pr(1, S_R, 0, "r");   pr(1, S_BN, 0, "bn");
    pr(1, S_HS, 1, "hs"); pr(1, S_VS, 1, "vs");
    reset = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    chk("rst_q_drain", rq.size(), 0);

    pv(0, 0, S_FS, 1, "fs2");  pv(0, 0, S_CYC, 1, "cyc2");
    pv(1, 0, S_X, 0, "x2");    pv(1, 0, S_Y, 0, "y2");
    pv(1, 0, S_FS, 1, "fs2");  pv(1, 0, S_CYC, 1, "cyc2");
    pv(1, 3, S_BN, 1, "bn2");  pv(1, 103, S_R, 100, "r2");
    reset = 1'b1;
    rel = cyc;
    drain("phase2_drain");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
